enemy_manager: RTL

ENEMY_MANAGER -- requirements
Module: enemy_manager

---
 rtl/enemy_manager_if.sv | 29 ++
 rtl/enemy_manager.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/enemy_manager_if.sv
// Enemy manager bus: frame strobe, game control, per-slot hit/ready inputs
// and the alive/grant/player status outputs.
//   master : game side (drives frame_clk, Game_Start, Enemy_Hit, Enemy_Attack_Ready)
//   slave  : enemy_manager (drives is_alive, Attack_Grant, Player_Damage,
//            Player_HP, Score, Game_State)
interface enemy_manager_if #(
    parameter int unsigned NUM_ENEMY = 4
);
    logic                 frame_clk;
    logic                 Game_Start;
    logic [NUM_ENEMY-1:0] Enemy_Hit;
    logic [NUM_ENEMY-1:0] Enemy_Attack_Ready;
    logic [NUM_ENEMY-1:0] is_alive;
    logic [NUM_ENEMY-1:0] Attack_Grant;
    logic                 Player_Damage;
    logic [3:0]           Player_HP;
    logic [15:0]          Score;
    logic [1:0]           Game_State;

    modport master (
        output frame_clk, Game_Start, Enemy_Hit, Enemy_Attack_Ready,
        input  is_alive, Attack_Grant, Player_Damage, Player_HP, Score, Game_State
    );

    modport slave (
        input  frame_clk, Game_Start, Enemy_Hit, Enemy_Attack_Ready,
        output is_alive, Attack_Grant, Player_Damage, Player_HP, Score, Game_State
    );
endinterface

// File: rtl/enemy_manager.sv
// Enemy manager: spawns enemies on a frame timer, retires them on hits,
// round-robin arbitrates enemy attacks against a cooldown and tracks player HP.
// Ports:
//   Clk, Reset_n : system clock, asynchronous active-low reset
//   bus (slave)  : frame_clk, Game_Start, Enemy_Hit, Enemy_Attack_Ready in;
//                  is_alive, Attack_Grant, Player_Damage, Player_HP, Score,
//                  Game_State out (all registered)
// Build option: ENEMY_MGR_SCORE_EN enables the saturating kill counter;
// without it Score is tied to zero.
module enemy_manager #(
    parameter int unsigned NUM_ENEMY       = 4,
    parameter int unsigned SPAWN_FRAMES    = 120,
    parameter int unsigned ATTACK_COOLDOWN = 30,
    parameter int unsigned PLAYER_HP_INIT  = 8
) (
    input  logic           Clk,
    input  logic           Reset_n,
    enemy_manager_if.slave bus
);
    localparam int unsigned PTR_W   = $clog2(NUM_ENEMY);
    localparam int unsigned SPAWN_W = $clog2(SPAWN_FRAMES + 1);
    localparam int unsigned CD_W    = (ATTACK_COOLDOWN > 0) ? $clog2(ATTACK_COOLDOWN + 1) : 1;

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_RUN  = 2'b01;
    localparam logic [1:0] ST_OVER = 2'b10;

    logic [1:0]           state_q, state_d;
    logic                 fc_q;
    logic [NUM_ENEMY-1:0] alive_q, alive_d;
    logic [NUM_ENEMY-1:0] grant_q, grant_d;
    logic                 dmg_q, dmg_d;
    logic [3:0]           hp_q, hp_d;
    logic [SPAWN_W-1:0]   spawn_q, spawn_d, spawn_inc_c;
    logic [CD_W-1:0]      cd_q, cd_d;
    logic [PTR_W-1:0]     ptr_q, ptr_d;

    logic                 frame_tick_c;
    logic [NUM_ENEMY-1:0] kill_c, cand_c, spawn_sel_c;
    logic                 spawn_any_c, rr_found_c;
    logic [PTR_W-1:0]     rr_idx_c;

`ifdef ENEMY_MGR_SCORE_EN
    logic [15:0] score_q, score_d, score_sat_c;
    logic [3:0]  kill_cnt_c;
    logic [16:0] score_sum_c;
`endif

    // One-cycle strobe on the rising edge of the sampled frame clock.
    assign frame_tick_c = bus.frame_clk & ~fc_q;
    assign kill_c       = bus.Enemy_Hit & alive_q;
    assign cand_c       = alive_q & bus.Enemy_Attack_Ready & ~bus.Enemy_Hit;
    assign spawn_inc_c  = (spawn_q == SPAWN_W'(SPAWN_FRAMES)) ? spawn_q : spawn_q + SPAWN_W'(1);

    // Lowest-index dead slot, taken from alive state before this cycle's kills.
    always_comb begin
        spawn_sel_c = '0;
        spawn_any_c = 1'b0;
        for (int i = 0; i < int'(NUM_ENEMY); i++) begin
            if (!alive_q[i] && !spawn_any_c) begin
                spawn_sel_c[i] = 1'b1;
                spawn_any_c    = 1'b1;
            end
        end
    end

    // Round-robin search starting at the pointer, wrapping to slot 0.
    always_comb begin
        rr_found_c = 1'b0;
        rr_idx_c   = '0;
        for (int k = 0; k < int'(NUM_ENEMY); k++) begin
            if (!rr_found_c && cand_c[(int'(ptr_q) + k) % int'(NUM_ENEMY)]) begin
                rr_found_c = 1'b1;
                rr_idx_c   = PTR_W'((int'(ptr_q) + k) % int'(NUM_ENEMY));
            end
        end
    end

`ifdef ENEMY_MGR_SCORE_EN
    // Kill popcount added to the score, saturating at all-ones.
    always_comb begin
        kill_cnt_c = '0;
        for (int i = 0; i < int'(NUM_ENEMY); i++) begin
            kill_cnt_c = kill_cnt_c + 4'(kill_c[i]);
        end
        score_sum_c = 17'(score_q) + 17'(kill_cnt_c);
        score_sat_c = score_sum_c[16] ? 16'hFFFF : score_sum_c[15:0];
    end
`endif

    // Next-state and datapath update.
    always_comb begin
        state_d = state_q;
        alive_d = alive_q;
        grant_d = '0;
        dmg_d   = 1'b0;
        hp_d    = hp_q;
        spawn_d = spawn_q;
        cd_d    = cd_q;
        ptr_d   = ptr_q;
`ifdef ENEMY_MGR_SCORE_EN
        score_d = score_q;
`endif
        case (state_q)
            ST_IDLE, ST_OVER: begin
                if (bus.Game_Start) begin
                    state_d = ST_RUN;
                    alive_d = '0;
                    spawn_d = '0;
                    cd_d    = '0;
                    ptr_d   = '0;
                    hp_d    = 4'(PLAYER_HP_INIT);
`ifdef ENEMY_MGR_SCORE_EN
                    score_d = '0;
`endif
                end
            end
            ST_RUN: begin
                if (hp_q == 4'd0) begin
                    state_d = ST_OVER;
                    alive_d = '0;
                end else begin
                    alive_d = alive_q & ~kill_c;
`ifdef ENEMY_MGR_SCORE_EN
                    score_d = score_sat_c;
`endif
                    if (frame_tick_c) begin
                        // Spawn fires on the tick that brings the timer to SPAWN_FRAMES.
                        if (spawn_inc_c == SPAWN_W'(SPAWN_FRAMES) && spawn_any_c) begin
                            alive_d = alive_d | spawn_sel_c;
                            spawn_d = '0;
                        end else begin
                            spawn_d = spawn_inc_c;
                        end
                        // The tick that expires the cooldown may grant, giving
                        // exactly ATTACK_COOLDOWN ticks between grants.
                        if (cd_q <= CD_W'(1) && rr_found_c) begin
                            grant_d = NUM_ENEMY'(1) << rr_idx_c;
                            dmg_d   = 1'b1;
                            hp_d    = hp_q - 4'd1;
                            cd_d    = CD_W'(ATTACK_COOLDOWN);
                            ptr_d   = (rr_idx_c == PTR_W'(NUM_ENEMY - 1)) ? '0 : rr_idx_c + PTR_W'(1);
                        end else if (cd_q != '0) begin
                            cd_d = cd_q - CD_W'(1);
                        end
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                alive_d = '0;
            end
        endcase
    end

    // State registers.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= ST_IDLE;
            fc_q    <= 1'b0;
            alive_q <= '0;
            grant_q <= '0;
            dmg_q   <= 1'b0;
            hp_q    <= '0;
            spawn_q <= '0;
            cd_q    <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            fc_q    <= bus.frame_clk;
            alive_q <= alive_d;
            grant_q <= grant_d;
            dmg_q   <= dmg_d;
            hp_q    <= hp_d;
            spawn_q <= spawn_d;
            cd_q    <= cd_d;
            ptr_q   <= ptr_d;
        end
    end

`ifdef ENEMY_MGR_SCORE_EN
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            score_q <= '0;
        end else begin
            score_q <= score_d;
        end
    end
    assign bus.Score = score_q;
`else
    assign bus.Score = 16'h0000;
`endif

    assign bus.is_alive      = alive_q;
    assign bus.Attack_Grant  = grant_q;
    assign bus.Player_Damage = dmg_q;
    assign bus.Player_HP     = hp_q;
    assign bus.Game_State    = state_q;
endmodule
